// File: rtl/dac_pkg.sv
// Shared types and constants for the two-requester serial DAC arbiter.
package dac_pkg;

    localparam int FRAME_BITS = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_HI,
        SHIFT_LO,
        GAP
    } arb_state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/dac_serializer.sv
// Serial engine: clocks one 16-bit word out MSB first with SCLK idling high,
// then holds the transmitted word on sample_out.
module dac_serializer
    import dac_pkg::*;
#(
    parameter int SCLK_DIV = 2
) (
    input  logic                  clk_in,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] start_data,
    output logic                  phase_end,
    output logic                  done,
    output logic                  dac_data,
    output logic                  dac_sclk,
    output logic                  dac_sync_n,
    output logic [FRAME_BITS-1:0] sample_out
);

    logic                  active_reg;
    logic [7:0]            div_reg;
    logic [4:0]            bit_cnt_reg;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] word_reg;
    logic                  sclk_reg;
    logic                  sync_n_reg;
    logic                  data_reg;
    logic [FRAME_BITS-1:0] sample_reg;

    // A phase (high or low half of SCLK) ends when the divider wraps.
    assign phase_end = active_reg && (div_reg == 8'(SCLK_DIV - 1));
    assign done      = phase_end && !sclk_reg && (bit_cnt_reg == 5'(FRAME_BITS));

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            active_reg  <= 1'b0;
            div_reg     <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            word_reg    <= '0;
            sclk_reg    <= 1'b1;
            sync_n_reg  <= 1'b1;
            data_reg    <= 1'b0;
            sample_reg  <= '0;
        end else if (!active_reg) begin
            if (start) begin
                active_reg  <= 1'b1;
                div_reg     <= '0;
                bit_cnt_reg <= '0;
                sync_n_reg  <= 1'b0;
                sclk_reg    <= 1'b1;
                data_reg    <= start_data[FRAME_BITS-1];
                shift_reg   <= {start_data[FRAME_BITS-2:0], 1'b0};
                word_reg    <= start_data;
            end
        end else begin
            div_reg <= phase_end ? '0 : div_reg + 8'd1;
            if (phase_end) begin
                if (sclk_reg) begin
                    // Falling edge: the DAC latches the bit currently on DAC_DATA.
                    sclk_reg    <= 1'b0;
                    bit_cnt_reg <= bit_cnt_reg + 5'd1;
                end else if (done) begin
                    active_reg  <= 1'b0;
                    sync_n_reg  <= 1'b1;
                    sclk_reg    <= 1'b1;
                    data_reg    <= 1'b0;
                    bit_cnt_reg <= '0;
                    sample_reg  <= word_reg;
                end else begin
                    sclk_reg  <= 1'b1;
                    data_reg  <= shift_reg[FRAME_BITS-1];
                    shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

    assign dac_data   = data_reg;
    assign dac_sclk   = sclk_reg;
    assign dac_sync_n = sync_n_reg;
    assign sample_out = sample_reg;

endmodule

// File: rtl/dac_sample_arbiter.sv
// Round-robin arbiter between two sample sources feeding one serial DAC;
// the frame FSM lives here, the bit-level timing in dac_serializer.
module dac_sample_arbiter
    import dac_pkg::*;
#(
    parameter int SCLK_DIV = 2,
    parameter int IDLE_GAP = 2
) (
    input  logic                  clk_in,
    input  logic                  reset_n,
    input  logic                  a_valid,
    input  logic [FRAME_BITS-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [FRAME_BITS-1:0] b_data,
    output logic                  b_ready,
    output logic                  DAC_DATA,
    output logic                  DAC_SCLK,
    output logic                  DAC_SYNC_n,
    output logic [FRAME_BITS-1:0] dac_data_out,
    output logic                  grant_id,
    output logic                  busy
);

    arb_state_t            state_reg, state_next;
    req_id_t               grant_reg, grant_next;
    logic                  run_reg;
    logic [7:0]            gap_cnt_reg;
    logic                  start;
    logic                  pick_b;
    logic [FRAME_BITS-1:0] start_data;
    logic                  phase_end;
    logic                  ser_done;

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        start      = 1'b0;
        pick_b     = 1'b0;
        start_data = a_data;
        case (state_reg)
            IDLE: begin
                // run_reg keeps ready low until one full edge has passed out of reset.
                if (run_reg && (a_valid || b_valid)) begin
                    pick_b     = (a_valid && b_valid) ? (grant_reg == REQ_A) : b_valid;
                    a_ready    = !pick_b;
                    b_ready    = pick_b;
                    start      = 1'b1;
                    start_data = pick_b ? b_data : a_data;
                    grant_next = pick_b ? REQ_B : REQ_A;
                    state_next = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_end) state_next = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (ser_done)       state_next = GAP;
                else if (phase_end) state_next = SHIFT_HI;
            end
            GAP: begin
                if (gap_cnt_reg == 8'(IDLE_GAP - 1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            grant_reg   <= REQ_B;
            run_reg     <= 1'b0;
            gap_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            run_reg     <= 1'b1;
            gap_cnt_reg <= (state_reg == GAP) ? gap_cnt_reg + 8'd1 : '0;
        end
    end

    dac_serializer #(
        .SCLK_DIV (SCLK_DIV)
    ) u_serializer (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .start      (start),
        .start_data (start_data),
        .phase_end  (phase_end),
        .done       (ser_done),
        .dac_data   (DAC_DATA),
        .dac_sclk   (DAC_SCLK),
        .dac_sync_n (DAC_SYNC_n),
        .sample_out (dac_data_out)
    );

    assign grant_id = grant_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_dac_sample_arbiter.sv
// Scoreboard bench for dac_sample_arbiter: randomized requesters, a cycle-level
// reference model of the arbitration rules, and a decoupled monitor.
module tb_dac_sample_arbiter;

    localparam int FRAME_CYC = 1 + 32 * 2 + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: default parameters
    logic        rst_n, a_valid, b_valid, a_ready, b_ready;
    logic [15:0] a_data, b_data, dac_out;
    logic        dac_data, dac_sclk, dac_sync_n, grant_id, busy;

    // Instance 1: fastest serial clock, shortest gap
    logic        rst1_n, a1_valid, b1_valid, a1_ready, b1_ready;
    logic [15:0] a1_data, b1_data, dac1_out;
    logic        dac1_data, dac1_sclk, dac1_sync_n, grant1_id, busy1;

    dac_sample_arbiter #(.SCLK_DIV(2), .IDLE_GAP(2)) dut (
        .clk_in(clk), .reset_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .DAC_DATA(dac_data), .DAC_SCLK(dac_sclk), .DAC_SYNC_n(dac_sync_n),
        .dac_data_out(dac_out), .grant_id(grant_id), .busy(busy)
    );

    dac_sample_arbiter #(.SCLK_DIV(1), .IDLE_GAP(1)) dut_fast (
        .clk_in(clk), .reset_n(rst1_n),
        .a_valid(a1_valid), .a_data(a1_data), .a_ready(a1_ready),
        .b_valid(b1_valid), .b_data(b1_data), .b_ready(b1_ready),
        .DAC_DATA(dac1_data), .DAC_SCLK(dac1_sclk), .DAC_SYNC_n(dac1_sync_n),
        .dac_data_out(dac1_out), .grant_id(grant1_id), .busy(busy1)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          id;
        logic [15:0] data;
        int          t;
    } exp_t;

    exp_t hs_q[$];
    exp_t frame_q[$];

    // Reference model: arbiter is free from idle_at onward; each grant occupies
    // exactly FRAME_CYC cycles; ties go to whoever was not granted last.
    bit model_en = 0;
    int idle_at  = 0;
    int last_id  = 1;
    always @(negedge clk) begin : model_p
        exp_t e;
        int   g;
        if (model_en && rst_n && cyc >= idle_at && (a_valid || b_valid)) begin
            g      = (a_valid && b_valid) ? (1 - last_id) : (b_valid ? 1 : 0);
            e.id   = g;
            e.data = g ? b_data : a_data;
            e.t    = cyc;
            hs_q.push_back(e);
            last_id = g;
            idle_at = cyc + FRAME_CYC;
        end
    end

    // Monitor: handshakes and serial frames against the expectation queues.
    bit          sb_en = 0;
    logic        sync_prev = 1'b1, sclk_prev = 1'b1;
    int          low_cnt = 0, nfall = 0, start_cyc = 0;
    logic [15:0] bits = '0;
    always @(negedge clk) begin : monitor_p
        exp_t e;
        #1;
        if (sb_en) begin
            if (a_ready || b_ready) begin
                check("ready_onehot", a_ready & b_ready, 0);
                if (hs_q.size() == 0) begin
                    check("ready_unexpected", cyc, 0);
                end else begin
                    e = hs_q.pop_front();
                    check("grant_source", b_ready, e.id);
                    check("grant_cycle", cyc, e.t);
                    frame_q.push_back(e);
                end
            end else if (hs_q.size() > 0 && hs_q[0].t < cyc) begin
                e = hs_q.pop_front();
                check("ready_missing_at_cycle", cyc, e.t);
            end

            if (!dac_sync_n) begin
                if (sync_prev) begin
                    low_cnt = 0; nfall = 0; bits = '0; start_cyc = cyc;
                end
                low_cnt++;
                if (sclk_prev && !dac_sclk) begin
                    bits = {bits[14:0], dac_data};
                    nfall++;
                end
            end else if (!sync_prev) begin
                if (frame_q.size() == 0) begin
                    check("frame_unexpected", bits, 0);
                end else begin
                    e = frame_q.pop_front();
                    $display("frame: src=%0d data=%h hs_cycle=%0d", e.id, e.data, e.t);
                    check("frame_start", start_cyc, e.t + 1);
                    check("sync_low_len", low_cnt, 64);
                    check("fall_edges", nfall, 16);
                    check("frame_bits", bits, e.data);
                    check("dac_data_out", dac_out, e.data);
                    check("grant_id_pin", grant_id, e.id);
                    check("gap_pins", {dac_sclk, dac_data}, 2'b10);
                end
            end
        end
        sync_prev = dac_sync_n;
        sclk_prev = dac_sclk;
    end

    // Randomized requester driver, honouring hold-until-ready with rare withdrawal.
    bit drv_en = 0;
    bit hold_mode = 0;
    bit hs_a, hs_b;

    task automatic step_req(input bit hs, inout logic v, inout logic [15:0] d);
        if (hs) begin
            if (!hold_mode) begin
                v = ($urandom_range(0, 3) == 0);
                d = 16'($urandom);
            end
        end else if (!v) begin
            if ($urandom_range(0, 7) == 0) begin
                v = 1'b1;
                d = 16'($urandom);
            end
        end else if (!hold_mode && $urandom_range(0, 63) == 0) begin
            v = 1'b0;
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        hs_a = a_valid && a_ready;
        hs_b = b_valid && b_ready;
        @(posedge clk);
        #1;
        if (drv_en) begin
            step_req(hs_a, a_valid, a_data);
            step_req(hs_b, b_valid, b_data);
        end
    end

    initial begin
        bit          hs;
        logic        prev;
        int          nf, low, tog_bad;
        logic [15:0] fbits;

        rst_n = 0; rst1_n = 0;
        a_valid = 0; b_valid = 0; a_data = '0; b_data = '0;
        a1_valid = 0; b1_valid = 0; a1_data = '0; b1_data = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sync_n", dac_sync_n, 1);
        check("rst_sclk", dac_sclk, 1);
        check("rst_data", dac_data, 0);
        check("rst_ready", {a_ready, b_ready}, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 1);
        check("rst_dac_out", dac_out, 0);

        // Abort a frame with reset after its 5th falling edge.
        @(posedge clk); #3;
        rst_n = 1;
        a_valid = 1; a_data = 16'h1234;
        hs = 0;
        for (int i = 0; i < 10 && !hs; i++) begin
            @(negedge clk);
            if (a_valid && a_ready) hs = 1;
        end
        check("abort_handshake", hs, 1);
        @(posedge clk); #1;
        a_valid = 0;
        nf = 0; prev = 1'b1;
        for (int i = 0; i < 200 && nf < 5; i++) begin
            @(negedge clk);
            if (prev && !dac_sclk) nf++;
            prev = dac_sclk;
        end
        check("abort_fall_count", nf, 5);
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        $display("abort: sync_n=%b sclk=%b busy=%b dac_out=%h", dac_sync_n, dac_sclk, busy, dac_out);
        check("abort_sync_n", dac_sync_n, 1);
        check("abort_sclk", dac_sclk, 1);
        check("abort_busy", busy, 0);
        check("abort_dac_out_kept", dac_out, 0);

        // Contention from reset, then randomized traffic.
        a_valid = 1; a_data = 16'h0001;
        b_valid = 1; b_data = 16'h8000;
        repeat (2) @(negedge clk);
        check("rst_ready_with_valid", {a_ready, b_ready}, 0);
        hold_mode = 1; drv_en = 1; sb_en = 1; model_en = 1;
        @(posedge clk); #3;
        last_id = 1;
        idle_at = cyc + 1;
        rst_n = 1;
        repeat (4 * FRAME_CYC + 10) @(posedge clk);
        hold_mode = 0;
        repeat (6000) @(posedge clk);
        drv_en = 0;
        #1;
        a_valid = 0; b_valid = 0;
        repeat (200) @(posedge clk);
        check("hs_queue_drained", hs_q.size(), 0);
        check("frame_queue_drained", frame_q.size(), 0);

        // Fast instance: SCLK_DIV=1, IDLE_GAP=1, alternating bits.
        @(posedge clk); #3;
        rst1_n = 1;
        a1_valid = 1; a1_data = 16'h5555;
        hs = 0;
        for (int i = 0; i < 10 && !hs; i++) begin
            @(negedge clk);
            if (a1_valid && a1_ready) hs = 1;
        end
        check("fast_handshake", hs, 1);
        check("fast_b_ready", b1_ready, 0);
        @(posedge clk); #1;
        a1_valid = 0;
        low = 0; tog_bad = 0; nf = 0; fbits = '0; prev = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!dac1_sync_n) begin
                if (low > 0 && dac1_sclk == prev) tog_bad++;
                if (prev && !dac1_sclk) begin
                    fbits = {fbits[14:0], dac1_data};
                    nf++;
                end
                low++;
            end
            prev = dac1_sclk;
        end
        $display("fast frame: low=%0d falls=%0d bits=%h out=%h", low, nf, fbits, dac1_out);
        check("fast_sync_low_len", low, 32);
        check("fast_sclk_toggle", tog_bad, 0);
        check("fast_fall_edges", nf, 16);
        check("fast_frame_bits", fbits, 16'h5555);
        check("fast_dac_out", dac1_out, 16'h5555);
        check("fast_idle_again", busy1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dac_sample_arbiter.md
DAC_SAMPLE_ARBITER -- requirements
Module: dac_sample_arbiter

Interface
REQ-001 Parameter SCLK_DIV, default 2: SCLK half-period in clk_in cycles; legal range 1..255.
REQ-002 Parameter IDLE_GAP, default 2: minimum DAC_SYNC_n-high cycles between frames; legal range 1..255.
REQ-003 clk_in  input  1  single system clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 a_valid  input  1  requester A has a sample.
REQ-006 a_data  input  16  requester A sample.
REQ-007 a_ready  output  1  one-cycle accept strobe to A.
REQ-008 b_valid / b_data / b_ready  in / in / out  1 / 16 / 1  same as A, for requester B.
REQ-009 DAC_DATA  output  1  serial data, MSB first.
REQ-010 DAC_SCLK  output  1  serial clock, idles high.
REQ-011 DAC_SYNC_n  output  1  frame enable, active low.
REQ-012 dac_data_out  output  16  last fully transmitted sample.
REQ-013 grant_id  output  1  source of current or last frame (0=A, 1=B).
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT_LO, SHIFT_HI and GAP.
REQ-016 In IDLE with at least one valid, the arbiter SHALL assert exactly one ready for one cycle; a handshake is valid&ready.
REQ-017 If only one requester is valid, it SHALL be granted.
REQ-018 If both are valid, the requester not granted last SHALL be granted; after reset, A wins the first tie.
REQ-019 On handshake at cycle T, the data SHALL be latched and grant_id updated.
REQ-020 At T+1 the block SHALL enter SHIFT_HI with DAC_SYNC_n=0, DAC_SCLK=1 and DAC_DATA=bit15.
REQ-021 SHIFT_HI and SHIFT_LO SHALL each last SCLK_DIV cycles with DAC_SCLK=1 and 0 respectively.
REQ-022 The SHIFT_HI->SHIFT_LO transition SHALL produce the falling edge on which the DAC latches.
REQ-023 The SHIFT_LO->SHIFT_HI transition SHALL advance DAC_DATA to the next lower bit.
REQ-024 A 5-bit bit counter SHALL count falling edges.
REQ-025 After the 16th SHIFT_LO completes, the block SHALL enter GAP with DAC_SYNC_n=1, DAC_SCLK=1 and DAC_DATA=0.
REQ-026 On the same cycle, dac_data_out SHALL take the transmitted sample.
REQ-027 DAC_SYNC_n SHALL be low for exactly 32*SCLK_DIV cycles per frame.
REQ-028 GAP SHALL last IDLE_GAP cycles and then return to IDLE.
REQ-029 ready SHALL never be asserted outside IDLE.
REQ-030 Requesters hold valid/data until ready; the arbiter SHALL ignore valid outside IDLE.
REQ-031 A valid deasserted before ready SHALL be treated as withdrawn, with no frame sent.
REQ-032 Peak throughput SHALL be one sample per 1+32*SCLK_DIV+IDLE_GAP cycles, with back-to-back frames alternating under contention.
REQ-033 The divider counter SHALL wrap at SCLK_DIV-1, and the bit counter SHALL never exceed 16.

Reset
REQ-034 On reset_n low, asynchronously: state=IDLE, DAC_SYNC_n=1, DAC_SCLK=1, DAC_DATA=0, a_ready=b_ready=0, busy=0, grant_id=1 (so A wins the first tie), dac_data_out=0, counters=0.
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately, without updating dac_data_out.
REQ-036 After reset release, the first handshake SHALL occur no earlier than the first clk_in edge with reset_n high.

Structure
REQ-037 Package dac_pkg SHALL hold the state enum, FRAME_BITS=16 and the requester-id typedef.
REQ-038 The serial engine (divider, bit counter, shift register, pins) SHALL be one sub-module, dac_serializer, with a start/done handshake.
REQ-039 The arbiter FSM SHALL remain in the top level.

Verification
REQ-040 Single A request a_data=16'hA5C3 -> a_ready at T, SYNC_n low T+1..T+64, 16 falling SCLK edges carrying 1010_0101_1100_0011, dac_data_out=16'hA5C3 at T+65.
REQ-041 A and B valid continuously from reset (A=16'h0001, B=16'h8000) -> grant order A,B,A,B; each next ready 67 cycles after the previous one.
REQ-042 Only B valid with 16'hFFFF -> b_ready only, DAC_DATA high for all 16 falling edges, grant_id=1.
REQ-043 reset_n pulsed low after the 5th falling edge -> same cycle: SYNC_n=1, SCLK=1, busy=0; dac_data_out keeps its previous value.
REQ-044 a_valid asserted during SHIFT_HI -> no a_ready until GAP ends, then handshake in the first IDLE cycle.
REQ-045 SCLK_DIV=1, IDLE_GAP=1, data 16'h5555 -> SCLK toggles every cycle, SYNC_n low 32 cycles, alternating DIN bits.
